// File: rtl/regfile_scan_checker.sv
// -----------------------------------------------------------------------------
// regfile_scan_checker
//
// Run-then-check controller for processor bring-up. It lets the CPU run for a
// programmable number of cycles and counts register writebacks. It then
// freezes the CPU, takes over regfile read port A and sweeps every register
// against an expected-value memory that has a 1-cycle synchronous read.
//
// Optional feature (macro REGSCAN_MASK_EN):
//   Adds input cmp_mask[NUM_REGS-1:0]. A register whose mask bit is 0 is never
//   counted as an error and never latched as the first error. Sweep timing does
//   not change. When the macro is undefined, every register is compared.
//
// Ports:
//   clock           system clock; all state changes on the rising edge
//   reset           asynchronous, active-high; clears all state
//   start           single-cycle pulse; begins a run (only from IDLE or DONE)
//   num_cycles      run length, sampled when start is accepted
//   cpu_rs1         processor read address for regfile port A
//   rwe, rd         processor writeback enable and destination register
//   reg_data        regfile port A read data (combinational)
//   exp_data        expected-memory read data (1-cycle synchronous)
//   rs1_out         regfile port A address (sweep index while test_mode)
//   exp_addr        expected-memory address (always the sweep index)
//   cpu_hold        stall request to the processor (low only during RUN)
//   test_mode       high while sweeping
//   busy            RUN or sweep in progress
//   done, pass      check complete / complete with zero errors
//   error_count     mismatch count, saturating
//   first_err_reg   index of the first mismatch; first_err_valid flags it
//   cycle_count     RUN cycles elapsed
//   wb_count        writebacks to rd != 0 during RUN, saturating
// -----------------------------------------------------------------------------
module regfile_scan_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CYCLE_W    = 16,
  parameter int ERR_W      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CYCLE_W-1:0]    num_cycles,
  input  logic [REG_ADDR_W-1:0] cpu_rs1,
  input  logic                  rwe,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic [DATA_WIDTH-1:0] exp_data,
`ifdef REGSCAN_MASK_EN
  input  logic [NUM_REGS-1:0]   cmp_mask,
`endif
  output logic [REG_ADDR_W-1:0] rs1_out,
  output logic [REG_ADDR_W-1:0] exp_addr,
  output logic                  cpu_hold,
  output logic                  test_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      error_count,
  output logic [REG_ADDR_W-1:0] first_err_reg,
  output logic                  first_err_valid,
  output logic [CYCLE_W-1:0]    cycle_count,
  output logic [CYCLE_W-1:0]    wb_count
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RUN       = 3'd1;
  localparam logic [2:0] SCAN_ADDR = 3'd2;
  localparam logic [2:0] SCAN_CMP  = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [REG_ADDR_W-1:0] idx;
  logic [CYCLE_W-1:0]    run_len;
  logic                  start_ok;
  logic                  cmp_en;
  logic                  mismatch;

  // start is only honoured when no run or sweep is in flight.
  assign start_ok = start && ((state == IDLE) || (state == DONE));

`ifdef REGSCAN_MASK_EN
  assign cmp_en = cmp_mask[idx];
`else
  assign cmp_en = 1'b1;
`endif

  assign mismatch = cmp_en && (reg_data != exp_data);

  assign rs1_out  = test_mode ? idx : cpu_rs1;
  assign exp_addr = idx;
  assign pass     = done && (error_count == '0);

  // NOTE: next_state gets a default before the case so no path can leave it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) next_state = (num_cycles == '0) ? SCAN_ADDR : RUN;
      end
      RUN: begin
        if (cycle_count == run_len - 1'b1) next_state = SCAN_ADDR;
      end
      SCAN_ADDR: next_state = SCAN_CMP;
      SCAN_CMP:  next_state = (idx == LAST_IDX) ? DONE : SCAN_ADDR;
      default:   next_state = IDLE;
    endcase
  end

  // Status outputs are registered from next_state so they line up with the
  // state register and all read 0 while reset is held. cpu_hold therefore
  // rises on the first clock after reset is released.
  // NOTE: every flop below uses non-blocking assignment so each reads the
  // pre-edge value of the others, regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      run_len         <= '0;
      cpu_hold        <= 1'b0;
      test_mode       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error_count     <= '0;
      first_err_reg   <= '0;
      first_err_valid <= 1'b0;
      cycle_count     <= '0;
      wb_count        <= '0;
    end else begin
      state     <= next_state;
      cpu_hold  <= (next_state != RUN);
      test_mode <= (next_state == SCAN_ADDR) || (next_state == SCAN_CMP);
      busy      <= (next_state == RUN) || (next_state == SCAN_ADDR) ||
                   (next_state == SCAN_CMP);
      done      <= (next_state == DONE);

      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            run_len         <= num_cycles;
            cycle_count     <= '0;
            wb_count        <= '0;
            error_count     <= '0;
            first_err_reg   <= '0;
            first_err_valid <= 1'b0;
            idx             <= '0;
          end
        end
        RUN: begin
          cycle_count <= cycle_count + 1'b1;
          // Writes to r0 are architecturally discarded, so they do not count.
          if (rwe && (rd != '0) && (wb_count != '1)) wb_count <= wb_count + 1'b1;
        end
        SCAN_CMP: begin
          // exp_data was addressed by idx during SCAN_ADDR and is valid now.
          if (mismatch) begin
            if (error_count != '1) error_count <= error_count + 1'b1;
            if (!first_err_valid) begin
              first_err_reg   <= idx;
              first_err_valid <= 1'b1;
            end
          end
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_scan_checker.sv
// -----------------------------------------------------------------------------
// tb_regfile_scan_checker
//
// Self-checking bench for regfile_scan_checker. The bench owns a regfile model
// (combinational read) and an expected-value memory (1-cycle synchronous read).
// For each run it predicts, from the array contents and the stimulus it drove,
// the error count, first mismatch, writeback count and phase lengths.
// Build with +define+REGSCAN_MASK_EN to exercise the compare mask.
// -----------------------------------------------------------------------------
module tb_regfile_scan_checker;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int EW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_cycles;
  logic [AW-1:0] cpu_rs1;
  logic          rwe;
  logic [AW-1:0] rd;
  logic [DW-1:0] reg_data;
  logic [DW-1:0] exp_data;
  logic [AW-1:0] rs1_out;
  logic [AW-1:0] exp_addr;
  logic          cpu_hold, test_mode, busy, done, pass;
  logic [EW-1:0] error_count;
  logic [AW-1:0] first_err_reg;
  logic          first_err_valid;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] wb_count;
  logic [NR-1:0] mask_v;

  logic [DW-1:0] regs    [NR];
  logic [DW-1:0] exp_mem [NR];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  regfile_scan_checker #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .REG_ADDR_W(AW), .CYCLE_W(CW), .ERR_W(EW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .cpu_rs1(cpu_rs1), .rwe(rwe), .rd(rd), .reg_data(reg_data),
    .exp_data(exp_data),
`ifdef REGSCAN_MASK_EN
    .cmp_mask(mask_v),
`endif
    .rs1_out(rs1_out), .exp_addr(exp_addr), .cpu_hold(cpu_hold),
    .test_mode(test_mode), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_err_reg(first_err_reg),
    .first_err_valid(first_err_valid), .cycle_count(cycle_count),
    .wb_count(wb_count)
  );

  assign reg_data = regs[rs1_out];
  always @(posedge clock) exp_data <= exp_mem[exp_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Fill regfile with random data (r0 = 0) and corrupt exp_mem where bad=1.
  task automatic load_mem(input logic [NR-1:0] bad);
    for (int i = 0; i < NR; i++) begin
      regs[i]    = (i == 0) ? '0 : DW'($urandom);
      exp_mem[i] = bad[i] ? (regs[i] ^ (DW'(1) << $urandom_range(DW - 1, 0))) : regs[i];
    end
  endtask

  // Start a run of num cycles and follow it to DONE, then compare against the
  // prediction. directed: writeback pattern rd=0 x3 then rd=7 x4.
  // inject: pulse start with a different length while busy.
  task automatic run_test(input string name, input int num, input bit directed,
                          input bit inject);
    int exp_err   = 0;
    int exp_first = 0;
    int exp_wb    = 0;
    int hold_low  = 0;
    int tm_cnt    = 0;
    int done_at   = -1;
    for (int i = NR - 1; i >= 0; i--) begin
      if (mask_v[i] && (regs[i] != exp_mem[i])) begin
        exp_err++;
        exp_first = i;
      end
    end
    @(negedge clock);
    start = 1'b1; num_cycles = CW'(num);
    rwe = 1'(($urandom)); rd = AW'($urandom); cpu_rs1 = AW'($urandom);
    for (int k = 1; k <= num + 2 * NR + 8; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (!cpu_hold) hold_low++;
      if (test_mode) tm_cnt++;
      if (done) begin
        done_at = k;
        break;
      end
      if (inject && k == 2) begin
        start = 1'b1; num_cycles = CW'(num + 5);
      end
      cpu_rs1 = AW'($urandom);
      rwe = 1'($urandom);
      rd  = AW'($urandom);
      if (directed) begin
        rwe = (k <= 7);
        rd  = (k <= 3) ? AW'(0) : AW'(7);
      end
      if (k <= num && rwe && rd != 0) exp_wb++;
    end
    start = 1'b0;
    if (done_at < 0) check({name, "_timeout"}, 0, 1);
    check({name, "_done_time"}, 64'(done_at), 64'(num + 2 * NR + 1));
    check({name, "_hold_low"}, 64'(hold_low), 64'(num));
    check({name, "_scan_len"}, 64'(tm_cnt), 64'(2 * NR));
    check({name, "_done"}, 64'(done), 1);
    check({name, "_pass"}, 64'(pass), 64'(exp_err == 0));
    check({name, "_err_cnt"}, 64'(error_count), 64'(exp_err));
    check({name, "_first_valid"}, 64'(first_err_valid), 64'(exp_err != 0));
    check({name, "_first_reg"}, 64'(first_err_reg), 64'(exp_err != 0 ? exp_first : 0));
    check({name, "_cycles"}, 64'(cycle_count), 64'(num));
    check({name, "_wb"}, 64'(wb_count), 64'(exp_wb));
    if (directed) check({name, "_wb_directed"}, 64'(wb_count), 4);
    check({name, "_busy"}, 64'(busy), 0);
    check({name, "_hold_done"}, 64'(cpu_hold), 1);
    check({name, "_tm_done"}, 64'(test_mode), 0);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_test_mode"}, 64'(test_mode), 0);
    check({name, "_rs1_out"}, 64'(rs1_out), 64'(cpu_rs1));
    check({name, "_outs"},
          {cpu_hold, busy, done, pass, error_count, first_err_reg,
           first_err_valid, cycle_count, wb_count, exp_addr}, '0);
  endtask

  initial begin
    logic [NR-1:0] bad;
    int guard;
    reset = 1'b1; start = 1'b0; num_cycles = '0; cpu_rs1 = 5'd13;
    rwe = 1'b0; rd = '0; mask_v = '1;
    load_mem('0);
    #23;
    check_cleared("reset");
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    check("idle_hold", 64'(cpu_hold), 1);

    run_test("match10", 10, 1'b0, 1'b0);

    bad = '0; bad[5] = 1'b1; bad[17] = 1'b1;
    load_mem(bad);
    run_test("corrupt_5_17", 10, 1'b0, 1'b0);
    check("corrupt_cnt_2", 64'(error_count), 2);
    check("corrupt_first_5", 64'(first_err_reg), 5);

    load_mem('0);
    run_test("zero_cycles", 0, 1'b0, 1'b0);
    run_test("wb_directed", 10, 1'b1, 1'b0);
    run_test("start_ignored", 12, 1'b0, 1'b1);

    // Reset in the middle of the sweep at index 9.
    bad = '0; bad[3] = 1'b1;
    load_mem(bad);
    @(negedge clock); start = 1'b1; num_cycles = 16'd3;
    guard = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      guard++;
    end while (!(test_mode && exp_addr == 5'd9) && guard < 200);
    if (guard >= 200) check("scan_idx9_timeout", 0, 1);
    cpu_rs1 = 5'd22;
    #2 reset = 1'b1;
    #1 check_cleared("mid_scan_reset");
    @(negedge clock); reset = 1'b0;
    load_mem('0);
    run_test("after_reset", 6, 1'b0, 1'b0);

`ifdef REGSCAN_MASK_EN
    bad = '0; bad[5] = 1'b1;
    load_mem(bad);
    mask_v = '1; mask_v[5] = 1'b0;
    run_test("mask_r5", 4, 1'b0, 1'b0);
    check("mask_r5_pass", 64'(pass), 1);
`endif

    for (int t = 0; t < 6; t++) begin
      bad = NR'($urandom & $urandom & $urandom);
      bad[0] = 1'b0;
      load_mem(bad);
`ifdef REGSCAN_MASK_EN
      mask_v = NR'($urandom | $urandom);
`endif
      run_test($sformatf("rand%0d", t), $urandom_range(40, 0), 1'b0, t[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scan_checker.md
Name: regfile_scan_checker

Overview:
- Synthesizable run-then-check controller for processor bring-up. It lets the CPU run for a programmable number of cycles while counting register writebacks.
- After the run it freezes the CPU and takes over regfile read port A. It sweeps all registers and compares each one against an expected-value memory.
- Reports error count, first mismatch and pass/done. Sits between processor, regfile and an expected-value ROM.

Parameters:
DATA_WIDTH, 32, register data width
NUM_REGS, 32, registers swept (indices 0..NUM_REGS-1)
REG_ADDR_W, 5, register index width; must satisfy 2**REG_ADDR_W >= NUM_REGS
CYCLE_W, 16, width of run-length and cycle/writeback counters
ERR_W, 8, width of error counter

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  single-cycle pulse; begins a run
num_cycles  in  CYCLE_W  run length, sampled on accepted start
cpu_rs1  in  REG_ADDR_W  processor's ctrl_readRegA
rwe  in  1  processor ctrl_writeEnable
rd  in  REG_ADDR_W  processor ctrl_writeReg
reg_data  in  DATA_WIDTH  regfile data_readRegA (combinational read)
exp_data  in  DATA_WIDTH  expected-memory data, 1-cycle synchronous read
rs1_out  out  REG_ADDR_W  read address to regfile port A
exp_addr  out  REG_ADDR_W  expected-memory address
cpu_hold  out  1  stall/clock-enable-low request to processor
test_mode  out  1  high while sweeping
busy  out  1  RUN or SCAN active
done  out  1  check complete
pass  out  1  done and zero errors
error_count  out  ERR_W  mismatches, saturating
first_err_reg  out  REG_ADDR_W  index of first mismatch
first_err_valid  out  1  at least one mismatch seen
cycle_count  out  CYCLE_W  run cycles elapsed
wb_count  out  CYCLE_W  writebacks to rd!=0 during RUN, saturating

Behaviour:
- Reset value of every output is 0; FSM resets to IDLE; rs1_out = cpu_rs1 (combinational mux).
- rs1_out = test_mode ? idx : cpu_rs1; exp_addr = idx always.
- States:
  - IDLE: cpu_hold=1. An accepted start latches num_cycles and clears cycle_count, wb_count, error_count, first_err_*, idx. Next state is RUN, or SCAN_ADDR directly if num_cycles==0.
  - RUN: cpu_hold=0. cycle_count +1 per clock. wb_count +1 when rwe && rd!=0. Go to SCAN_ADDR in the cycle cycle_count==latched-1, so the RUN cycle count equals num_cycles exactly.
  - SCAN_ADDR: test_mode=1, cpu_hold=1. Drives idx; exp memory samples it. Next state is SCAN_CMP.
  - SCAN_CMP: test_mode=1. Compares reg_data vs exp_data (full DATA_WIDTH, exact).
    - On mismatch: error_count +1, saturating at 2**ERR_W-1. If first_err_valid==0, latch first_err_reg=idx and set first_err_valid.
    - If idx==NUM_REGS-1, go to DONE; else idx+1 and go to SCAN_ADDR.
    - The sweep therefore takes exactly 2*NUM_REGS cycles.
  - DONE: done=1, cpu_hold=1, pass=(error_count==0). Results hold until the next start. start in DONE behaves like start in IDLE (restart).
- busy = state is RUN, SCAN_ADDR or SCAN_CMP.
- start while busy is ignored; num_cycles is not re-sampled.
- rwe during SCAN or DONE is not counted.
- Reset asserted mid-RUN or mid-SCAN returns immediately to IDLE: test_mode=0, rs1_out reverts to cpu_rs1, results cleared.
- Register 0 is compared like any other register; the expected memory must hold 0 there.

Optional Feature:
- Macro REGSCAN_MASK_EN.
- When defined: extra input cmp_mask, width NUM_REGS. In SCAN_CMP a register whose mask bit is 0 is never counted as an error and never latched as first error. Sweep timing is unchanged.
- When undefined: no cmp_mask port; every register is compared.

Test Plan:
- num_cycles=10, expected memory equal to regfile contents -> cpu_hold low exactly 10 cycles; SCAN lasts 64 cycles; done=1, pass=1, error_count=0, cycle_count=10.
- Expected memory corrupted at r5 and r17 -> error_count=2, first_err_reg=5, first_err_valid=1, pass=0.
- num_cycles=0 -> no RUN cycles; SCAN_ADDR entered the cycle after start; cycle_count=0; done after 64 cycles.
- During RUN drive rwe=1 with rd=0 on 3 cycles and rd=7 on 4 cycles -> wb_count=4.
- Reset asserted in SCAN at idx=9 -> same-cycle test_mode=0, rs1_out==cpu_rs1, all outputs 0. A new start performs a full clean run.
- start pulsed during RUN with a different num_cycles -> ignored; run length unchanged. With REGSCAN_MASK_EN and cmp_mask bit 5 cleared, an r5 mismatch alone gives pass=1.
